// File: rtl/alu_pkg.sv
// Shared opcode encodings and pipeline sizing helper for the ALU datapath.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of result bits produced by each pipeline stage.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its top bit.
module add_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] total;

  assign total    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum      = total[CHUNK-1:0];
  assign cout     = total[CHUNK];
  // The top sum bit is a ^ b ^ carry-in, so the carry-in falls out by xor.
  assign c_msb_in = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract split over STAGES register stages with a
// valid/ready handshake; the whole pipe advances as one unit.
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if ((WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be divisible by STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // Inputs seen by each stage: port operands for stage 0, registers after that.
  logic [WIDTH-1:0] st_a  [STAGES];
  logic [WIDTH-1:0] st_b  [STAGES];
  logic [WIDTH-1:0] st_r  [STAGES];
  logic             st_c  [STAGES];
  logic             st_v  [STAGES];

  logic [WIDTH-1:0] sum_c;
  logic             cout_c [STAGES];
  logic             cmsb_c [STAGES];
  logic [WIDTH-1:0] res_d  [STAGES];

  // Stage registers: skewed operands, partial result, carry and valid.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic              c_q   [STAGES];
  logic [STAGES-1:0] vld_q;
  logic              ovf_q;

  // Single global enable: move when the output slot is empty or being drained.
  assign adv      = out_ready | ~vld_q[STAGES-1];
  assign in_ready = adv;
  assign b_eff    = (op_sub == OP_SUB) ? ~data_operandB : data_operandB;

  // Route each stage's inputs and merge its chunk sum into the partial result.
  always_comb begin
    st_a[0] = data_operandA;
    st_b[0] = b_eff;
    st_r[0] = '0;
    st_c[0] = (op_sub != OP_ADD);
    st_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_r[k] = res_q[k-1];
      st_c[k] = c_q[k-1];
      st_v[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      res_d[k] = st_r[k];
      res_d[k][k*CHUNK +: CHUNK] = sum_c[k*CHUNK +: CHUNK];
    end
  end

  // One adder slice per stage, each working on its own chunk of the operands.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .a        (st_a[k][k*CHUNK +: CHUNK]),
      .b        (st_b[k][k*CHUNK +: CHUNK]),
      .cin      (st_c[k]),
      .sum      (sum_c[k*CHUNK +: CHUNK]),
      .cout     (cout_c[k]),
      .c_msb_in (cmsb_c[k])
    );
  end

  // Pipeline registers; data only loads behind a valid token so outputs hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        c_q[k]   <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= st_v[k];
        if (st_v[k]) begin
          a_q[k]   <= st_a[k];
          b_q[k]   <= st_b[k];
          res_q[k] <= res_d[k];
          c_q[k]   <= cout_c[k];
        end
      end
      if (st_v[STAGES-1]) begin
        ovf_q <= cmsb_c[STAGES-1] ^ cout_c[STAGES-1];
      end
    end
  end

  assign out_valid   = vld_q[STAGES-1];
  assign data_result = res_q[STAGES-1];
  assign carry_out   = c_q[STAGES-1];
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: 32/4 main instance plus 16-bit
// instances with 1, 2 and 16 stages.
module tb_pipelined_add_sub;
  import alu_pkg::*;

  localparam int S  = 4;
  localparam int NV = 11;
  localparam int NSW = 15;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        v;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        lat;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Main 32-bit / 4-stage instance.
  logic        in_valid, in_ready, op_sub, out_valid, out_ready, carry_out, overflow;
  logic [31:0] data_a, data_b, data_result;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_operandA(data_a), .data_operandB(data_b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_result(data_result), .carry_out(carry_out), .overflow(overflow)
  );

  // 16-bit instances sharing one stimulus stream.
  logic        sw_valid, sw_sub, sw_out_ready;
  logic [15:0] sw_a, sw_b;
  logic [2:0]  s_in_ready, s_out_valid, s_c, s_v;
  logic [15:0] s_res [3];

  pipelined_add_sub #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clock(clock), .reset(reset), .in_valid(sw_valid), .in_ready(s_in_ready[0]),
    .data_operandA(sw_a), .data_operandB(sw_b), .op_sub(sw_sub),
    .out_valid(s_out_valid[0]), .out_ready(sw_out_ready),
    .data_result(s_res[0]), .carry_out(s_c[0]), .overflow(s_v[0])
  );
  pipelined_add_sub #(.WIDTH(16), .STAGES(2)) u_s2 (
    .clock(clock), .reset(reset), .in_valid(sw_valid), .in_ready(s_in_ready[1]),
    .data_operandA(sw_a), .data_operandB(sw_b), .op_sub(sw_sub),
    .out_valid(s_out_valid[1]), .out_ready(sw_out_ready),
    .data_result(s_res[1]), .carry_out(s_c[1]), .overflow(s_v[1])
  );
  pipelined_add_sub #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clock(clock), .reset(reset), .in_valid(sw_valid), .in_ready(s_in_ready[2]),
    .data_operandA(sw_a), .data_operandB(sw_b), .op_sub(sw_sub),
    .out_valid(s_out_valid[2]), .out_ready(sw_out_ready),
    .data_result(s_res[2]), .carry_out(s_c[2]), .overflow(s_v[2])
  );

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    popped = 0;
  string tag = "init";
  exp_t  exp_q [$];
  exp_t  sw_q  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h (cycle %0d)", tag, name, act, req, cyc);
    end
  endtask

  // One cycle on the main DUT: drive, retire/compare the head result, record acceptance.
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic isub, input logic [31:0] eres, input logic ec,
                      input logic ev, input logic ordy, input logic lat, output logic acc);
    exp_t e;
    in_valid  = iv;
    data_a    = ia;
    data_b    = ib;
    op_sub    = isub;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", 64'(data_result), 64'(e.res));
        chk("carry", 64'(carry_out), 64'(e.c));
        chk("overflow", 64'(overflow), 64'(e.v));
        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(S));
        popped++;
      end
    end
    acc = iv && in_ready && !reset;
    if (acc) begin
      e.res = eres; e.c = ec; e.v = ev; e.lat = lat; e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int t = 0; t < budget && exp_q.size() != 0; t++)
      step(1'b0, 32'd0, 32'd0, OP_ADD, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [NV];
    logic        acc;
    int          j;
    int          sidx;
    int          npop0;
    int          sdone [3];
    int          sst [3];
    logic        ordy;
    logic [33:0] snap;
    exp_t        se;

    vt[0]  = '{32'h0000_0000, 32'h0000_0000, OP_ADD, 32'h0000_0000, 1'b0, 1'b0};
    vt[1]  = '{32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000, 1'b1, 1'b1};
    vt[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1};
    vt[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0};
    vt[4]  = '{32'h00FF_FFFF, 32'h0000_0001, OP_ADD, 32'h0100_0000, 1'b0, 1'b0};
    vt[5]  = '{32'h0000_0005, 32'h0000_0007, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[6]  = '{32'h0000_0007, 32'h0000_0005, OP_SUB, 32'h0000_0002, 1'b1, 1'b0};
    vt[7]  = '{32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[8]  = '{32'h1234_5678, 32'h0FED_CBA9, OP_ADD, 32'h2222_2221, 1'b0, 1'b0};
    vt[9]  = '{32'h0000_0000, 32'h0000_0000, OP_SUB, 32'h0000_0000, 1'b1, 1'b0};
    vt[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, OP_SUB, 32'h8000_0000, 1'b0, 1'b1};
    sst[0] = 1; sst[1] = 2; sst[2] = 16;

    reset = 1'b1; in_valid = 1'b0; data_a = '0; data_b = '0; op_sub = OP_ADD; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = OP_ADD; sw_out_ready = 1'b1;
    repeat (3) @(negedge clock);

    tag = "reset";
    chk("out_valid", 64'(out_valid), 64'd0);
    chk("data_result", 64'(data_result), 64'd0);
    chk("carry", 64'(carry_out), 64'd0);
    chk("overflow", 64'(overflow), 64'd0);
    chk("small_out_valid", 64'(s_out_valid), 64'd0);
    reset = 1'b0;

    // Single operations, latency checked.
    for (int i = 0; i < NV; i++) begin
      tag = $sformatf("vec%0d", i);
      step(1'b1, vt[i].a, vt[i].b, vt[i].sub, vt[i].res, vt[i].c, vt[i].v, 1'b1, 1'b1, acc);
      chk("accepted", 64'(acc), 64'd1);
      drain(20);
    end

    // Back-to-back shift sweep.
    tag = "sweep32";
    for (int i = 0; i <= 30; i++) begin
      step(1'b1, 32'd1 << i, 32'd1 << i, OP_ADD, 32'd1 << (i + 1), 1'b0, (i == 30), 1'b1, 1'b1, acc);
    end
    drain(20);

    // Back-pressure: 8 adds with a 3-cycle stall on a valid result.
    tag = "bp";
    j = 0; sidx = 0; npop0 = popped; snap = '0;
    for (int t = 0; t < 80; t++) begin
      if (j >= 8 && exp_q.size() == 0) break;
      if (sidx == 0 && out_valid) begin
        sidx = 1;
        snap = {data_result, carry_out, overflow};
      end else if (sidx >= 1 && sidx <= 3) begin
        chk("hold", 64'({out_valid, data_result, carry_out, overflow}), 64'({1'b1, snap}));
        sidx++;
      end
      ordy = (sidx < 1 || sidx > 3);
      if (!ordy) begin
        out_ready = 1'b0;
        #1;
        chk("in_ready_low", 64'(in_ready), 64'd0);
      end
      step(j < 8, 32'(j * 3 + 1), 32'(j * 7 + 100), OP_ADD, 32'(j * 10 + 101), 1'b0, 1'b0,
           ordy, 1'b0, acc);
      if (acc) j++;
    end
    chk("stall_seen", 64'(sidx), 64'd4);
    chk("count", 64'(popped - npop0), 64'd8);
    chk("left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Reset with three operations in flight; nothing may emerge afterwards.
    tag = "rst_mid";
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'(k + 10), 32'd1, OP_ADD, 32'(k + 11), 1'b0, 1'b0, 1'b1, 1'b0, acc);
    reset = 1'b1;
    step(1'b1, 32'd99, 32'd1, OP_ADD, 32'd100, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    chk("accept_in_reset", 64'(acc), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    chk("out_valid", 64'(out_valid), 64'd0);
    chk("data_result", 64'(data_result), 64'd0);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      cyc++;
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    tag = "post_rst";
    step(1'b1, 32'd3, 32'd4, OP_ADD, 32'd7, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    drain(20);

    // 16-bit sweep on the 1-, 2- and 16-stage instances.
    tag = "sweep16";
    for (int d = 0; d < 3; d++) sdone[d] = 0;
    for (int i = 0; i < NSW + 24; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (s_out_valid[d]) begin
          if (sdone[d] >= sw_q.size()) begin
            chk($sformatf("spurious_s%0d", sst[d]), 64'(s_out_valid[d]), 64'd0);
          end else begin
            se = sw_q[sdone[d]];
            chk($sformatf("res_s%0d", sst[d]), 64'(s_res[d]), 64'(se.res[15:0]));
            chk($sformatf("carry_s%0d", sst[d]), 64'(s_c[d]), 64'(se.c));
            chk($sformatf("ovf_s%0d", sst[d]), 64'(s_v[d]), 64'(se.v));
            chk($sformatf("lat_s%0d", sst[d]), 64'(cyc - se.cyc), 64'(sst[d]));
            sdone[d]++;
          end
        end
      end
      if (i < NSW) begin
        sw_valid = 1'b1;
        sw_a = 16'd1 << i;
        sw_b = 16'd1 << i;
        #1;
        chk("in_ready", 64'(s_in_ready), 64'h7);
        se.res = 32'(16'd1 << (i + 1)); se.c = 1'b0; se.v = (i == 14); se.lat = 1'b1; se.cyc = cyc;
        sw_q.push_back(se);
      end else begin
        sw_valid = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("count_s%0d", sst[d]), 64'(sdone[d]), 64'(NSW));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit add circuit.
- Adds or subtracts two WIDTH-bit operands across STAGES register stages, one chunk of bits per stage.
- Uses a valid/ready handshake on both sides and flags carry and signed overflow.
- Sits in the datapath between the operand-select logic and the ALU result mux, so the ALU can close timing at wider WIDTH.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH). Each stage adds CHUNK = WIDTH/STAGES bits.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands and op are presented this cycle
- in_ready  out  1  block accepts the operands this cycle
- data_operandA  in  WIDTH  operand A
- data_operandB  in  WIDTH  operand B
- op_sub  in  1  0 = A+B, 1 = A-B
- out_valid  out  1  result is presented
- out_ready  in  1  consumer accepts the result
- data_result  out  WIDTH  sum or difference, modulo 2^WIDTH
- carry_out  out  1  carry from the MSB; for subtract, 1 means no borrow
- overflow  out  1  signed two's-complement overflow

Behaviour:
- Reset (synchronous, sampled on the clock edge while reset=1):
  - All stage valid bits clear; out_valid=0; data_result=0; carry_out=0; overflow=0.
  - in_ready may be 1 during reset, but no transfer is accepted while reset=1.
  - Reset mid-operation discards all in-flight operations. Nothing emerges afterwards.
- Pipeline advance:
  - Global enable adv = out_ready | ~out_valid. in_ready = adv.
  - The whole pipeline shifts only when adv=1 (no per-stage bubble collapse).
- Acceptance: an input is accepted on a clock edge where in_valid & in_ready & ~reset.
- Latency: with out_ready held high, the result appears STAGES cycles after acceptance (out_valid on the STAGES-th edge after acceptance). Throughput is 1 per cycle.
- Operand preparation at acceptance: B' = op_sub ? ~B : B; cin0 = op_sub.
- Stage k (0..STAGES-1):
  - Computes bits [k*CHUNK +: CHUNK] of A + B' + cin_k.
  - Registers the chunk sum and carry c_{k+1}.
  - Forwards the still-unused high operand chunks and the already-computed low result chunks (skew/deskew registers).
- Final stage:
  - carry_out = c_STAGES.
  - overflow = carry into the MSB XOR carry out of the MSB, computed from the last chunk's internal carries.
- Back-pressure: while out_valid=1 and out_ready=0:
  - data_result, carry_out, overflow and out_valid hold stable.
  - in_ready=0; no stage changes.
- Simultaneous events:
  - out_ready=1 with in_valid=1 on a full pipe: accept the new input and retire the oldest result in the same cycle.
  - Reset overrides both.
- Output registers hold their last value when out_valid=0 (not forced to 0 except by reset).
- No combinational path from in_valid or data inputs to outputs. in_ready depends combinationally only on out_ready and out_valid.
- STAGES=1 degenerates to a single registered adder: latency 1.
- An illegal parameter combination (WIDTH % STAGES != 0) is stopped by an elaboration-time check.

Decomposition:
- Package alu_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - A function returning CHUNK from WIDTH and STAGES.
- Sub-module add_slice:
  - Parameter CHUNK; purely combinational.
  - Inputs a, b, cin. Outputs sum, cout, and c_msb_in (carry into the top bit, for overflow).
  - Instantiated STAGES times by a generate loop.
- Pipeline registers, skew registers and the handshake live in pipelined_add_sub.

Test Plan:
- Zero: A=0, B=0, add, out_ready=1 -> after 4 cycles data_result=0x00000000, carry_out=0, overflow=0.
- Shift sweep:
  - Stimulus: for i=0..30, A=B=1<<i, add, back-to-back every cycle.
  - Required response: data_result=1<<(i+1), in order, one per cycle after a 4-cycle fill.
  - Also: A=B=0x80000000 -> result 0, carry_out=1, overflow=1.
- Boundaries:
  - 0x7FFFFFFF+1 -> 0x80000000, carry_out=0, overflow=1.
  - 0xFFFFFFFF+1 -> 0x00000000, carry_out=1, overflow=0.
  - Chunk-crossing 0x00FFFFFF+1 -> 0x01000000.
- Subtract:
  - 5-7 -> 0xFFFFFFFE, carry_out=0, overflow=0.
  - 7-5 -> 0x00000002, carry_out=1.
  - 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
- Back-pressure:
  - Stimulus: stream 8 adds, drop out_ready for 3 cycles while out_valid=1.
  - Required response: in_ready=0 and outputs stable for those 3 cycles; all 8 results in order, none duplicated or lost.
- Reset mid-flight and parameter sweep:
  - Assert reset for 1 cycle with 3 operations in flight -> out_valid=0 next cycle; no stale result ever emerges.
  - Repeat the shift sweep with WIDTH=16 and STAGES in {1, 2, 16}; latency equals STAGES.
